// File: rtl/fixed_point_sub_scheduler.sv
// Round-robin scheduler sharing one registered Q-format subtract unit
// between NUM_REQ requesters. Each operation walks IDLE -> CALC -> DONE.
module fixed_point_sub_scheduler #(
   parameter int Q       = 8,
   parameter int N       = 16,
   parameter int NUM_REQ = 4,
   parameter int SAT     = 0,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*N-1:0] req_a,
   input  logic [NUM_REQ*N-1:0] req_b,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [N-1:0]         res_data,
   output logic [IDW-1:0]       res_id,
   output logic                 res_ovf,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t       state, state_nxt;
   logic [IDW-1:0] rr_ptr, rr_nxt;
   logic [IDW-1:0] gnt_idx;
   logic           gnt_any;
   logic           accept;
   int unsigned    scan;
   int unsigned    wrap;

   logic [N-1:0]   op_a, op_b;
   logic [IDW-1:0] op_id;
   logic [N-1:0]   diff, res_nxt;
   logic           ovf;

   // The binary point position never affects the subtraction itself.
   if (Q < 0 || Q >= N) begin : g_q_range
      $error("fixed_point_sub_scheduler: Q must lie in [0, N-1]");
   end

   // Round-robin scan starting at rr_ptr; first valid requester wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      scan    = 0;
      wrap    = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan = (32'(rr_ptr) + k) % NUM_REQ;
         if (!gnt_any && req_valid[scan[IDW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = scan[IDW-1:0];
         end
      end
      wrap   = (32'(gnt_idx) + 1) % NUM_REQ;
      rr_nxt = wrap[IDW-1:0];
   end

   assign accept = (state == IDLE) && gnt_any;

   // Next-state logic and the combinational grant strobe.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (gnt_any) begin
               state_nxt = CALC;
               if (rst_n) req_ready[gnt_idx] = 1'b1;
            end
         end
         CALC: state_nxt = DONE;
         DONE: if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Low N bits of the sign-extended difference equal the plain N-bit
   // difference, so the extension is implicit here.
   always_comb begin
      diff    = op_a - op_b;
      ovf     = (op_a[N-1] != op_b[N-1]) && (diff[N-1] != op_a[N-1]);
      res_nxt = diff;
      if (SAT != 0 && ovf) begin
         res_nxt = op_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
   end

   // State register and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= '0;
      end else begin
         state <= state_nxt;
         if (accept) rr_ptr <= rr_nxt;
      end
   end

   // Operand capture on accept and result register on CALC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a      <= '0;
         op_b      <= '0;
         op_id     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
         res_ovf   <= 1'b0;
      end else begin
         if (accept) begin
            op_a  <= req_a[gnt_idx*N +: N];
            op_b  <= req_b[gnt_idx*N +: N];
            op_id <= gnt_idx;
         end
         if (state == CALC) begin
            res_data  <= res_nxt;
            res_ovf   <= ovf;
            res_id    <= op_id;
            res_valid <= 1'b1;
         end else if (state == DONE && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
